// File: rtl/vga_mem_arbiter.sv
// -----------------------------------------------------------------------------
// vga_mem_arbiter
//
// Shares one single-port pixel memory between the display fetch path and the
// drawing engine. During active video the display fetch wins. During blanking
// (hblnk | vblnk) the drawing engine wins. A lone requester is always granted,
// whatever the window.
//
// Each accepted request is registered into a memory command one cycle after
// the grant. Read data from the memory arrives one cycle after that. It is
// steered back to the requester that issued the read, using a delayed owner
// tag. Draw writes return nothing.
//
// Optional feature (macro VGA_ARB_STARVE_GUARD_EN):
//   An 8-bit starvation counter tracks how long the drawing engine has been
//   blocked. When the counter reaches MAX_WAIT, the next draw request is
//   granted over the display, even during active video. The FSM state is then
//   FORCE. The default build has no counter and no FORCE state.
//
// Parameters:
//   ADDR_W    memory address width
//   DATA_W    pixel word width (RGB 4:4:4)
//   MAX_WAIT  starvation limit in cycles (guard only), legal range 2..255
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   hblnk, vblnk                   blanking flags from the timing controller
//   disp_req/addr/gnt              display read request, address, accept
//   disp_rdata/rvalid              display read data return
//   drw_req/we/addr/wdata/gnt      draw request (read or write), accept
//   drw_rdata/rvalid               draw read data return
//   mem_en/we/addr/wdata           registered memory command
//   mem_rdata                      memory read data (1 cycle after mem_en)
// -----------------------------------------------------------------------------
module vga_mem_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 12,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hblnk,
  input  logic              vblnk,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              drw_req,
  input  logic              drw_we,
  input  logic [ADDR_W-1:0] drw_addr,
  input  logic [DATA_W-1:0] drw_wdata,
  output logic              drw_gnt,
  output logic [DATA_W-1:0] drw_rdata,
  output logic              drw_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (MAX_WAIT < 2 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("vga_mem_arbiter: MAX_WAIT must be in 2..255");
  end

  // The state names the owner of the memory command being issued this cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DISP  = 2'd1,
    DRAW  = 2'd2
`ifdef VGA_ARB_STARVE_GUARD_EN
    ,
    FORCE = 2'd3
`endif
  } state_t;

  state_t state;

  logic blank;
  logic force_drw;
  logic drw_win;
  logic drw_owner;

  assign blank = hblnk | vblnk;

`ifdef VGA_ARB_STARVE_GUARD_EN
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [7:0] starve_cnt;

  // The guard only overrides when the display would otherwise win.
  // Outside that case the draw grant is an ordinary DRAW.
  assign force_drw = (starve_cnt == MAX_WAIT_C) & drw_req & disp_req & ~blank;
  assign drw_owner = (state == DRAW) || (state == FORCE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (drw_gnt) begin
      starve_cnt <= '0;
    end else if (drw_req) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end
`else
  assign force_drw = 1'b0;
  assign drw_owner = (state == DRAW);
`endif

  // Draw wins in blanking, when it is alone, or when the guard fires.
  // Otherwise the display takes the slot.
  // NOTE: grants are combinational, so they are gated with rst directly.
  // This keeps every output at 0 while reset is held, even with requests present.
  assign drw_win  = drw_req & (blank | ~disp_req | force_drw);
  assign drw_gnt  = rst & drw_win;
  assign disp_gnt = rst & disp_req & ~drw_win;

  // The command is live exactly when a grant was given last cycle.
  assign mem_en = (state != IDLE);

  // Read data is presented only during the matching valid pulse.
  assign disp_rdata = disp_rvalid ? mem_rdata : '0;
  assign drw_rdata  = drw_rvalid  ? mem_rdata : '0;

  // NOTE: all sequential state uses non-blocking assignments. Each register
  // then samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      disp_rvalid <= 1'b0;
      drw_rvalid  <= 1'b0;
    end else begin
      // The return tag is the current owner plus "is a read". It is delayed
      // by one register so it lines up with mem_rdata. Display commands are
      // always reads.
      disp_rvalid <= (state == DISP);
      drw_rvalid  <= drw_owner & ~mem_we;

      if (disp_gnt) begin
        state    <= DISP;
        mem_we   <= 1'b0;
        mem_addr <= disp_addr;
      end else if (drw_gnt) begin
`ifdef VGA_ARB_STARVE_GUARD_EN
        state     <= force_drw ? FORCE : DRAW;
`else
        state     <= DRAW;
`endif
        mem_we    <= drw_we;
        mem_addr  <= drw_addr;
        mem_wdata <= drw_wdata;
      end else begin
        // The address and write data hold their last values while idle.
        state  <= IDLE;
        mem_we <= 1'b0;
      end
    end
  end

endmodule
